// File: rtl/frogger_game_ctrl.sv
// Frogger round sequencer: start-button synchroniser, round FSM, lives/level
// bookkeeping, score and respawn strobes, and per-lane speed dividers that
// shrink as the level rises.
module frogger_game_ctrl #(
  parameter int LIVES_INIT   = 3,
  parameter int LEVEL_MAX    = 9,
  parameter int DEATH_FRAMES = 60,
  parameter int WIN_FRAMES   = 30,
  parameter int DIV_W        = 23,
  parameter int DIV_STEP     = 250000,
  parameter int DIV_MIN      = 1000000,
  parameter logic [8*DIV_W-1:0] BASE_DIV = {
    DIV_W'(5000000), DIV_W'(4500000), DIV_W'(3000000), DIV_W'(5000000),
    DIV_W'(3500000), DIV_W'(4000000), DIV_W'(2500000), DIV_W'(3000000)}
) (
  input  logic               VGA_CLK,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               collision,
  input  logic               reached_goal,
  input  logic               start_n,
  output logic [2:0]         state,
  output logic               play_en,
  output logic               frog_reset,
  output logic               score_inc,
  output logic               score_dec,
  output logic               score_clr,
  output logic [1:0]         lives,
  output logic [3:0]         level,
  output logic               flash,
  output logic [8*DIV_W-1:0] lane_div
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY     = 3'd1,
    S_DYING    = 3'd2,
    S_SCORED   = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  localparam int FRAMES_MAX = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
  localparam int CNT_W      = $clog2(FRAMES_MAX + 1);

  state_t             state_q, state_d;
  logic [1:0]         lives_q, lives_d;
  logic [3:0]         level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frog_q, frog_d;
  logic               inc_q, inc_d;
  logic               dec_q, dec_d;
  logic               clr_q, clr_d;
  logic               flash_q, flash_d;
  logic               play_en_q, play_en_d;
  logic               sync1_q, sync2_q, sync3_q;
  logic               start_p;
  logic [8*DIV_W-1:0] lane_q, lane_d;

  // Lives can only go down by one and never wrap below zero.
  function automatic logic [1:0] lives_sat_dec(input logic [1:0] l);
    return (l == 2'd0) ? 2'd0 : l - 2'd1;
  endfunction

  // Level climbs by one and sticks at the top level.
  function automatic logic [3:0] level_sat_inc(input logic [3:0] l);
    return (l >= 4'(LEVEL_MAX)) ? 4'(LEVEL_MAX) : l + 4'd1;
  endfunction

  // Base divider minus the level reduction, floored so no lane gets too fast.
  function automatic logic [DIV_W-1:0] lane_floor(input logic [DIV_W-1:0] base,
                                                  input logic [3:0] lvl);
    logic [DIV_W+3:0] p;
    logic [DIV_W+4:0] lim;
    p   = (DIV_W+4)'(lvl) * (DIV_W+4)'(DIV_STEP);
    lim = {1'b0, p} + (DIV_W+5)'(DIV_MIN);
    if ({5'b0, base} < lim) return DIV_W'(DIV_MIN);
    return base - p[DIV_W-1:0];
  endfunction

  // Start button: two-flop synchroniser plus one delay flop for edge detect.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= start_n;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign start_p = sync3_q & ~sync2_q;

  // Round state register.
  always_ff @(posedge VGA_CLK) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Round transitions; goal beats collision, timers count frame ticks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_GAMEOVER: if (start_p) state_d = S_PLAY;
      S_PLAY: begin
        if (reached_goal)   state_d = S_SCORED;
        else if (collision) state_d = S_DYING;
      end
      S_DYING:
        if (frame_tick && cnt_q == CNT_W'(DEATH_FRAMES - 1))
          state_d = (lives_q == 2'd0) ? S_GAMEOVER : S_PLAY;
      S_SCORED:
        if (frame_tick && cnt_q == CNT_W'(WIN_FRAMES - 1)) state_d = S_PLAY;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition taken.
  always_comb begin
    lives_d = lives_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    frog_d  = 1'b0;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      S_IDLE, S_GAMEOVER:
        if (start_p) begin
          lives_d = 2'(LIVES_INIT);
          level_d = 4'd0;
          frog_d  = 1'b1;
          clr_d   = 1'b1;
        end
      S_PLAY: begin
        if (reached_goal) begin
          inc_d = 1'b1;
          cnt_d = '0;
        end else if (collision) begin
          dec_d   = 1'b1;
          lives_d = lives_sat_dec(lives_q);
          cnt_d   = '0;
        end
      end
      S_DYING:
        if (frame_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_d == S_PLAY) frog_d = 1'b1;
        end
      S_SCORED:
        if (frame_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_d == S_PLAY) begin
            frog_d  = 1'b1;
            level_d = level_sat_inc(level_q);
          end
        end
      default: ;
    endcase
    play_en_d = (state_d == S_PLAY);
    flash_d   = (state_d == S_DYING) ? cnt_d[3] : (state_d == S_SCORED);
  end

  // Output and bookkeeping registers.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      lives_q   <= 2'd0;
      level_q   <= 4'd0;
      cnt_q     <= '0;
      frog_q    <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      clr_q     <= 1'b0;
      flash_q   <= 1'b0;
      play_en_q <= 1'b0;
    end else begin
      lives_q   <= lives_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      frog_q    <= frog_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      clr_q     <= clr_d;
      flash_q   <= flash_d;
      play_en_q <= play_en_d;
    end
  end

  // Per-lane divider for the current level.
  always_comb begin
    lane_d = '0;
    for (int i = 0; i < 8; i++)
      lane_d[DIV_W*i +: DIV_W] = lane_floor(BASE_DIV[DIV_W*i +: DIV_W], level_q);
  end

  // Lane dividers trail the level register by one cycle.
  always_ff @(posedge VGA_CLK) begin
    if (reset) lane_q <= BASE_DIV;
    else       lane_q <= lane_d;
  end

  assign state      = state_q;
  assign play_en    = play_en_q;
  assign frog_reset = frog_q;
  assign score_inc  = inc_q;
  assign score_dec  = dec_q;
  assign score_clr  = clr_q;
  assign lives      = lives_q;
  assign level      = level_q;
  assign flash      = flash_q;
  assign lane_div   = lane_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Bench for frogger_game_ctrl: directed game scenarios plus a random soak,
// checked every cycle against a frame-level game model.
module tb_frogger_game_ctrl;
  localparam int DW = 23;

  logic          VGA_CLK = 1'b0;
  logic          reset, frame_tick, collision, reached_goal, start_n;
  logic [2:0]    state;
  logic          play_en, frog_reset, score_inc, score_dec, score_clr, flash;
  logic [1:0]    lives;
  logic [3:0]    level;
  logic [8*DW-1:0] lane_div;

  frogger_game_ctrl dut (
    .VGA_CLK(VGA_CLK), .reset(reset), .frame_tick(frame_tick),
    .collision(collision), .reached_goal(reached_goal), .start_n(start_n),
    .state(state), .play_en(play_en), .frog_reset(frog_reset),
    .score_inc(score_inc), .score_dec(score_dec), .score_clr(score_clr),
    .lives(lives), .level(level), .flash(flash), .lane_div(lane_div)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Game model: 0 idle, 1 play, 2 dying, 3 scored, 4 game over.
  int m_state, m_lives, m_level, m_ticks, m_frog, m_inc, m_dec, m_clr, m_flash;
  int hist[3];
  int base_div[8] = '{3000000, 2500000, 4000000, 3500000,
                      5000000, 3000000, 4500000, 5000000};
  logic [8*DW-1:0] m_lane;

  function automatic int lane_ref(int base, int lvl);
    longint p, b;
    p = longint'(lvl) * 250000;
    b = base;
    if (b < p + 1000000) return 1000000;
    return int'(b - p);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(string tag, logic [8*DW-1:0] obs, logic [8*DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented to it.
  task automatic model_edge();
    bit sp;
    if (reset) begin
      m_state = 0; m_lives = 0; m_level = 0; m_ticks = 0;
      m_frog = 0; m_inc = 0; m_dec = 0; m_clr = 0; m_flash = 0;
      hist = '{1, 1, 1};
      for (int i = 0; i < 8; i++) m_lane[DW*i +: DW] = DW'(base_div[i]);
      return;
    end
    for (int i = 0; i < 8; i++) m_lane[DW*i +: DW] = DW'(lane_ref(base_div[i], m_level));
    sp = (hist[1] == 0) && (hist[2] == 1);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = int'(start_n);
    m_frog = 0; m_inc = 0; m_dec = 0; m_clr = 0;
    if (m_state == 0 || m_state == 4) begin
      if (sp) begin
        m_state = 1; m_lives = 3; m_level = 0; m_frog = 1; m_clr = 1;
      end
    end else if (m_state == 1) begin
      if (reached_goal) begin
        m_state = 3; m_inc = 1; m_ticks = 0;
      end else if (collision) begin
        m_state = 2; m_dec = 1; m_ticks = 0;
        if (m_lives > 0) m_lives--;
      end
    end else if (m_state == 2) begin
      if (frame_tick) begin
        m_ticks++;
        if (m_ticks == 60) begin
          if (m_lives == 0) m_state = 4;
          else begin m_state = 1; m_frog = 1; end
        end
      end
    end else if (m_state == 3) begin
      if (frame_tick) begin
        m_ticks++;
        if (m_ticks == 30) begin
          m_state = 1; m_frog = 1;
          m_level = (m_level + 1 > 9) ? 9 : m_level + 1;
        end
      end
    end
    m_flash = (m_state == 2) ? ((m_ticks >> 3) & 1) : ((m_state == 3) ? 1 : 0);
  endtask

  task automatic check_all();
    chk("state", 32'(state), m_state);
    chk("play_en", 32'(play_en), (m_state == 1) ? 1 : 0);
    chk("frog_reset", 32'(frog_reset), m_frog);
    chk("score_inc", 32'(score_inc), m_inc);
    chk("score_dec", 32'(score_dec), m_dec);
    chk("score_clr", 32'(score_clr), m_clr);
    chk("lives", 32'(lives), m_lives);
    chk("level", 32'(level), m_level);
    chk("flash", 32'(flash), m_flash);
    chk_lane("lane_div", lane_div, m_lane);
  endtask

  task automatic cyc();
    @(posedge VGA_CLK);
    model_edge();
    #1;
    check_all();
  endtask

  // Clock until the model reaches the target state, then confirm the DUT is there.
  task automatic run_until(string tag, int target, int limit, bit rand_tick);
    int k = 0;
    while (m_state != target && k < limit) begin
      frame_tick = rand_tick ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      k++;
    end
    frame_tick = 1'b0;
    chk(tag, 32'(state), target);
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; collision = 1'b0;
    reached_goal = 1'b0; start_n = 1'b1;
    repeat (2) cyc();
    chk("reset_lane0", 32'(lane_div[DW-1:0]), 3000000);
    reset = 1'b0;
    cyc();

    // Start: state reaches PLAY on the third edge after start_n falls.
    start_n = 1'b0;
    cyc(); cyc();
    chk("start_not_yet", 32'(state), 0);
    cyc();
    chk("start_play", 32'(state), 1);
    chk("start_lives", 32'(lives), 3);
    start_n = 1'b1;
    repeat (3) cyc();

    // One death and respawn.
    collision = 1'b1; cyc(); collision = 1'b0;
    chk("death_state", 32'(state), 2);
    chk("death_lives", 32'(lives), 2);
    run_until("respawn_play", 1, 400, 1'b1);

    // Goal and collision together: goal wins.
    reached_goal = 1'b1; collision = 1'b1; cyc();
    reached_goal = 1'b0; collision = 1'b0;
    chk("goal_state", 32'(state), 3);
    chk("goal_lives", 32'(lives), 2);
    run_until("goal_play", 1, 200, 1'b1);
    chk("goal_level", 32'(level), 1);
    cyc();
    chk("goal_lane0", 32'(lane_div[DW-1:0]), 2750000);

    // Lose the remaining lives.
    for (int d = 0; d < 2; d++) begin
      collision = 1'b1; cyc(); collision = 1'b0;
      run_until("dying_exit", (d == 1) ? 4 : 1, 400, 1'b1);
    end
    chk("gameover_play_en", 32'(play_en), 0);
    collision = 1'b1; reached_goal = 1'b1; frame_tick = 1'b1;
    repeat (5) cyc();
    collision = 1'b0; reached_goal = 1'b0; frame_tick = 1'b0;
    chk("gameover_hold", 32'(state), 4);

    // Restart from game over.
    start_n = 1'b0;
    run_until("restart_play", 1, 10, 1'b1);
    chk("restart_lives", 32'(lives), 3);
    chk("restart_level", 32'(level), 0);
    start_n = 1'b1;
    cyc();

    // Twelve goals: level saturates and dividers floor.
    for (int g = 0; g < 12; g++) begin
      reached_goal = 1'b1; cyc(); reached_goal = 1'b0;
      run_until("goal_loop", 1, 100, 1'b0);
    end
    cyc();
    chk("max_level", 32'(level), 9);
    chk("max_lane1", 32'(lane_div[DW*1 +: DW]), 1000000);
    chk("max_lane3", 32'(lane_div[DW*3 +: DW]), 1250000);
    chk("max_lane4", 32'(lane_div[DW*4 +: DW]), 2750000);

    // Random soak including occasional mid-game resets.
    for (int c = 0; c < 5000; c++) begin
      reset        = ($urandom_range(0, 999) == 0);
      frame_tick   = 1'($urandom_range(0, 1));
      collision    = ($urandom_range(0, 39) == 0);
      reached_goal = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) start_n = ~start_n;
      cyc();
    end

    // Reset from an active state lands in IDLE with no strobes.
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("final_reset_state", 32'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
